// File: rtl/key_event_tracker_if.sv
// rtl/key_event_tracker_if.sv - keycode report in, per-channel key events out
interface key_event_tracker_if #(
    parameter int NUM_SLOTS = 6,
    parameter int NUM_KEYS  = 8
);
    logic                   sample_en;
    logic [NUM_SLOTS*8-1:0] keycodes;
    logic [NUM_KEYS*8-1:0]  targets;
    logic [NUM_KEYS-1:0]    repeat_en;
    logic [NUM_KEYS-1:0]    key_on;
    logic [NUM_KEYS-1:0]    key_press;
    logic [NUM_KEYS-1:0]    key_release;
    logic [NUM_KEYS-1:0]    key_repeat;
    logic                   rollover;

    modport master (
        output sample_en, keycodes, targets, repeat_en,
        input  key_on, key_press, key_release, key_repeat, rollover
    );

    modport slave (
        input  sample_en, keycodes, targets, repeat_en,
        output key_on, key_press, key_release, key_repeat, rollover
    );
endinterface

// File: rtl/key_event_tracker.sv
// rtl/key_event_tracker.sv - multi-key held/press/release/typematic tracker
module key_event_tracker #(
    parameter int NUM_SLOTS     = 6,
    parameter int NUM_KEYS      = 8,
    parameter int REPEAT_DELAY  = 30,
    parameter int REPEAT_PERIOD = 6,
    parameter int CNT_W         = 8
) (
    input logic Clk,
    input logic Reset,
    key_event_tracker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

    logic [NUM_KEYS-1:0] on_q, on_n;
    logic [NUM_KEYS-1:0] phase_q, phase_n;
    logic [NUM_KEYS-1:0] press_q, press_n;
    logic [NUM_KEYS-1:0] rel_q, rel_n;
    logic [NUM_KEYS-1:0] rpt_q, rpt_n;
    logic                roll_q, roll_n;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_n [NUM_KEYS];

    logic [NUM_KEYS-1:0] raw;
    logic                phantom;
    rpt_state_t          st [NUM_KEYS];

    always_comb begin
        phantom = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (bus.keycodes[8*s +: 8] == 8'h01) phantom = 1'b1;
        end
        for (int k = 0; k < NUM_KEYS; k++) begin
            raw[k] = 1'b0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (bus.keycodes[8*s +: 8] == bus.targets[8*k +: 8]) raw[k] = 1'b1;
            end
            if (bus.targets[8*k +: 8] == 8'h00) raw[k] = 1'b0;
        end
    end

    // Repeat phase is encoded as key_on plus one phase bit per channel.
    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (!on_q[k])        st[k] = IDLE;
            else if (phase_q[k]) st[k] = REPEAT;
            else                 st[k] = DELAY;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            on_q    <= '0;
            phase_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            rpt_q   <= '0;
            roll_q  <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
        end else begin
            on_q    <= on_n;
            phase_q <= phase_n;
            press_q <= press_n;
            rel_q   <= rel_n;
            rpt_q   <= rpt_n;
            roll_q  <= roll_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        on_n    = on_q;
        phase_n = phase_q;
        cnt_n   = cnt_q;
        roll_n  = roll_q;
        press_n = '0;
        rel_n   = '0;
        rpt_n   = '0;
        if (bus.sample_en) begin
            roll_n = phantom;
            if (!phantom) begin
                on_n    = raw;
                press_n = raw & ~on_q;
                rel_n   = ~raw & on_q;
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if (!raw[k]) begin
                        phase_n[k] = 1'b0;
                        cnt_n[k]   = '0;
                    end else begin
                        unique case (st[k])
                            IDLE: begin
                                // Press is hold sample 1; a delay of one repeats on the press itself.
                                cnt_n[k] = CNT_W'(1);
                                if (REPEAT_DELAY == 1) begin
                                    rpt_n[k]   = bus.repeat_en[k];
                                    phase_n[k] = 1'b1;
                                end else begin
                                    phase_n[k] = 1'b0;
                                end
                            end
                            DELAY: begin
                                if (cnt_q[k] + CNT_W'(1) == CNT_W'(REPEAT_DELAY)) begin
                                    rpt_n[k]   = bus.repeat_en[k];
                                    phase_n[k] = 1'b1;
                                    cnt_n[k]   = CNT_W'(1);
                                end else begin
                                    cnt_n[k] = cnt_q[k] + CNT_W'(1);
                                end
                            end
                            REPEAT: begin
                                if (cnt_q[k] == CNT_W'(REPEAT_PERIOD)) begin
                                    rpt_n[k] = bus.repeat_en[k];
                                    cnt_n[k] = CNT_W'(1);
                                end else begin
                                    cnt_n[k] = cnt_q[k] + CNT_W'(1);
                                end
                            end
                            default: cnt_n[k] = '0;
                        endcase
                    end
                end
            end
        end
    end

    assign bus.key_on      = on_q;
    assign bus.key_press   = press_q;
    assign bus.key_release = rel_q;
    assign bus.key_repeat  = rpt_q;
    assign bus.rollover    = roll_q;
endmodule

// File: tb/tb_key_event_tracker.sv
// tb/tb_key_event_tracker.sv - randomized bench against a hold-count reference model
module tb_key_event_tracker;
    localparam int NS = 6;
    localparam int NK = 8;
    localparam int RD = 3;
    localparam int RP = 2;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    key_event_tracker_if #(.NUM_SLOTS(NS), .NUM_KEYS(NK)) bus ();

    key_event_tracker #(
        .NUM_SLOTS(NS), .NUM_KEYS(NK),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(8)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    logic [7:0]    kc [NS];
    logic [7:0]    tg [NK];
    logic [NK-1:0] ren;

    logic [NK-1:0] m_on, m_press, m_rel, m_rpt;
    logic          m_roll;
    int            hold [NK];

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: each channel tracks how many consecutive valid samples it has been held.
    task automatic model(input bit sen, input bit rst);
        bit            phantom;
        logic [NK-1:0] raw;
        m_press = '0;
        m_rel   = '0;
        m_rpt   = '0;
        if (rst) begin
            m_on   = '0;
            m_roll = 1'b0;
            for (int k = 0; k < NK; k++) hold[k] = 0;
            return;
        end
        if (!sen) return;
        phantom = 1'b0;
        for (int s = 0; s < NS; s++) if (kc[s] == 8'h01) phantom = 1'b1;
        if (phantom) begin
            m_roll = 1'b1;
            return;
        end
        m_roll = 1'b0;
        for (int k = 0; k < NK; k++) begin
            raw[k] = 1'b0;
            if (tg[k] != 8'h00)
                for (int s = 0; s < NS; s++) if (kc[s] == tg[k]) raw[k] = 1'b1;
            hold[k]  = raw[k] ? hold[k] + 1 : 0;
            m_rpt[k] = raw[k] && ren[k] && hold[k] >= RD && ((hold[k] - RD) % RP) == 0;
        end
        m_press = raw & ~m_on;
        m_rel   = ~raw & m_on;
        m_on    = raw;
    endtask

    task automatic step(input bit sen, input bit rst);
        @(negedge Clk);
        Reset         = rst;
        bus.sample_en = sen;
        for (int s = 0; s < NS; s++) bus.keycodes[8*s +: 8] = kc[s];
        for (int k = 0; k < NK; k++) bus.targets[8*k +: 8] = tg[k];
        bus.repeat_en = ren;
        @(posedge Clk);
        #1;
        model(sen, rst);
        check("key_on",      32'(bus.key_on),      32'(m_on));
        check("key_press",   32'(bus.key_press),   32'(m_press));
        check("key_release", 32'(bus.key_release), 32'(m_rel));
        check("key_repeat",  32'(bus.key_repeat),  32'(m_rpt));
        check("rollover",    32'(bus.rollover),    32'(m_roll));
    endtask

    task automatic clear_kc();
        for (int s = 0; s < NS; s++) kc[s] = 8'h00;
    endtask

    function automatic logic [7:0] pick_code();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return 8'h00;
        if (r < 6) return 8'h1A;
        if (r < 8) return 8'h2C;
        if (r < 9) return 8'h04;
        return 8'h16;
    endfunction

    initial begin
        int rc;
        clear_kc();
        for (int k = 0; k < NK; k++) tg[k] = 8'h00;
        ren = '0;

        step(1'b0, 1'b1);
        check("reset_on", 32'(bus.key_on), 32'h0);

        tg[0] = 8'h1A;
        kc[2] = 8'h1A;
        step(1'b1, 1'b0);
        check("w_press", 32'(bus.key_press[0]), 32'h1);
        step(1'b0, 1'b0);
        check("w_press_one_clk", 32'(bus.key_press[0]), 32'h0);
        clear_kc();
        step(1'b1, 1'b0);
        check("w_release", 32'(bus.key_release[0]), 32'h1);

        for (int pass = 0; pass < 2; pass++) begin
            ren[0] = (pass == 0);
            kc[2]  = 8'h1A;
            rc     = 0;
            for (int i = 0; i < 8; i++) begin
                step(1'b1, 1'b0);
                rc += 32'(bus.key_repeat[0]);
                step(1'b0, 1'b0);
                rc += 32'(bus.key_repeat[0]);
            end
            check(pass == 0 ? "repeat_count_en" : "repeat_count_dis", rc, pass == 0 ? 3 : 0);
            check("held_on", 32'(bus.key_on[0]), 32'h1);
            clear_kc();
            step(1'b1, 1'b0);
        end

        ren[0] = 1'b1;
        kc[2]  = 8'h1A;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        kc[0] = 8'h01;
        step(1'b1, 1'b0);
        check("rollover_set", 32'(bus.rollover), 32'h1);
        check("rollover_hold_on", 32'(bus.key_on[0]), 32'h1);
        clear_kc();
        step(1'b1, 1'b0);
        check("rollover_clear", 32'(bus.rollover), 32'h0);
        check("rollover_release", 32'(bus.key_release[0]), 32'h1);

        tg[1] = 8'h00;
        tg[2] = 8'h2C;
        tg[3] = 8'h2C;
        step(1'b1, 1'b0);
        check("zero_target_off", 32'(bus.key_on[1]), 32'h0);
        kc[0] = 8'h2C;
        kc[5] = 8'h2C;
        kc[2] = 8'h1A;
        step(1'b1, 1'b0);
        check("dual_press", 32'(bus.key_press[3:2]), 32'h3);

        step(1'b0, 1'b1);
        check("midhold_reset_rel", 32'(bus.key_release), 32'h0);
        step(1'b1, 1'b0);
        check("after_reset_press", 32'(bus.key_press[3:0]), 32'hD);

        for (int i = 0; i < 100; i++) begin
            for (int s = 0; s < NS; s++) kc[s] = pick_code();
            step(1'b0, 1'b0);
        end

        for (int k = 0; k < NK; k++) tg[k] = pick_code();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int s = 0; s < NS; s++) kc[s] = pick_code();
                if ($urandom_range(0, 19) == 0) kc[$urandom_range(0, NS-1)] = 8'h01;
            end
            if ($urandom_range(0, 29) == 0) tg[$urandom_range(0, NK-1)] = pick_code();
            if ($urandom_range(0, 19) == 0) ren = NK'($urandom);
            step(1'($urandom_range(0, 1)), $urandom_range(0, 199) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
